// File: rtl/pal_macrocell_core_pkg.sv
// Shared types and bitstream layout helpers for the PAL macrocell core.
package pal_macrocell_core_pkg;

   // Control FSM: fabric is dark until a complete bitstream is applied.
   typedef enum logic {
      ST_UNCFG  = 1'b0,
      ST_ACTIVE = 1'b1
   } pal_state_e;

   // Total bitstream length: AND plane, OR plane, two macrocell bits per output.
   function automatic int cfg_len_f(input int n, input int p, input int m);
      return 2*n*p + m*p + 2*m;
   endfunction

   // AND plane starts at bit 0; term p literal i sits at p*2N+2i (true) / +1 (complement).
   function automatic int and_base_f();
      return 0;
   endfunction

   // OR plane: bit or_base + m*P + p connects term p to output m.
   function automatic int or_base_f(input int n, input int p);
      return 2*n*p;
   endfunction

   // Macrocell bits: mc_base + 2m = registered, +2m+1 = invert.
   function automatic int mc_base_f(input int n, input int p, input int m);
      return 2*n*p + m*p;
   endfunction

endpackage

// File: rtl/pal_macrocell_core_if.sv
// Configuration and logic-signal bundle between a host and the PAL core.
interface pal_macrocell_core_if #(
   parameter int N = 8,
   parameter int M = 4
);
   logic         cfg_shift;
   logic         cfg_in;
   logic         cfg_apply;
   logic [N-1:0] in_vars;
   logic [M-1:0] out_vals;
   logic         cfg_out;
   logic         cfg_ready;
   logic         cfg_err;
   logic         active;

   modport master (
      output cfg_shift, cfg_in, cfg_apply, in_vars,
      input  out_vals, cfg_out, cfg_ready, cfg_err, active
   );

   modport slave (
      input  cfg_shift, cfg_in, cfg_apply, in_vars,
      output out_vals, cfg_out, cfg_ready, cfg_err, active
   );
endinterface

// File: rtl/pal_macrocell_core_macrocell.sv
// One output macrocell: OR of connected terms, optional invert, optional flop.
module pal_macrocell #(
   parameter int P = 11
) (
   input  logic         clk,
   input  logic         res,
   input  logic         active,
   input  logic         clr,
   input  logic [P-1:0] terms,
   input  logic [P-1:0] or_mask,
   input  logic         reg_en,
   input  logic         inv,
   output logic         out_val
);
   logic sum;
   logic flop;

   assign sum = (|(terms & or_mask)) ^ inv;

   // Output flop: cleared on reset and on a committed apply, tracks sum while active.
   always_ff @(posedge clk) begin
      if (res)
         flop <= 1'b0;
      else if (clr)
         flop <= 1'b0;
      else if (active)
         flop <= sum;
   end

   // Unconfigured fabric drives 0; otherwise pick registered or combinational path.
   always_comb begin
      out_val = 1'b0;
      if (active)
         out_val = reg_en ? flop : sum;
   end
endmodule

// File: rtl/pal_macrocell_core.sv
// Serially configured PAL: shadow/active config, AND/OR planes, M macrocells.
module pal_macrocell_core
   import pal_macrocell_core_pkg::*;
#(
   parameter int N = 8,
   parameter int P = 11,
   parameter int M = 4
) (
   input  logic                  clk,
   input  logic                  res,
   pal_macrocell_core_if.slave   bus
);
   localparam int CFG_LEN = cfg_len_f(N, P, M);
   localparam int CW      = $clog2(CFG_LEN + 2);
   localparam int AND_B   = and_base_f();
   localparam int OR_B    = or_base_f(N, P);
   localparam int MC_B    = mc_base_f(N, P, M);
   localparam logic [CW-1:0] CNT_FULL = CW'(CFG_LEN);
   localparam logic [CW-1:0] CNT_OVF  = CW'(CFG_LEN + 1);

   logic [CFG_LEN-1:0] shadow;
   logic [CFG_LEN-1:0] active_cfg;
   logic [CW-1:0]      bit_cnt;
   pal_state_e         state;
   logic               cfg_err_q;
   logic               apply_ok;
   logic               is_active;
   logic [P-1:0]       terms;
   logic [M-1:0]       out_w;

   assign apply_ok  = bus.cfg_apply && (bit_cnt == CNT_FULL);
   assign is_active = (state == ST_ACTIVE);

   // Config loader and FSM. Apply wins over shift in the same cycle and is
   // judged on the pre-shift count; a partial or overlong load is rejected.
   always_ff @(posedge clk) begin
      if (res) begin
         shadow     <= '0;
         active_cfg <= '0;
         bit_cnt    <= '0;
         cfg_err_q  <= 1'b0;
         state      <= ST_UNCFG;
      end else if (bus.cfg_apply) begin
         if (bit_cnt == CNT_FULL) begin
            active_cfg <= shadow;
            bit_cnt    <= '0;
            cfg_err_q  <= 1'b0;
            state      <= ST_ACTIVE;
         end else begin
            cfg_err_q  <= 1'b1;
         end
      end else if (bus.cfg_shift) begin
         shadow <= {shadow[CFG_LEN-2:0], bus.cfg_in};
         if (bit_cnt != CNT_OVF)
            bit_cnt <= bit_cnt + 1'b1;
      end
   end

   // AND plane: a term with no literal selected must read 0, not the empty-AND 1.
   for (genvar gp = 0; gp < P; gp++) begin : g_term
      logic [N-1:0] t_sel;
      logic [N-1:0] c_sel;
      for (genvar gi = 0; gi < N; gi++) begin : g_lit
         assign t_sel[gi] = active_cfg[AND_B + gp*2*N + 2*gi];
         assign c_sel[gi] = active_cfg[AND_B + gp*2*N + 2*gi + 1];
      end
      assign terms[gp] = (|(t_sel | c_sel)) &
                         (&((~t_sel | bus.in_vars) & (~c_sel | ~bus.in_vars)));
   end

   for (genvar gm = 0; gm < M; gm++) begin : g_mc
      pal_macrocell #(.P(P)) u_mc (
         .clk     (clk),
         .res     (res),
         .active  (is_active),
         .clr     (apply_ok),
         .terms   (terms),
         .or_mask (active_cfg[OR_B + gm*P +: P]),
         .reg_en  (active_cfg[MC_B + 2*gm]),
         .inv     (active_cfg[MC_B + 2*gm + 1]),
         .out_val (out_w[gm])
      );
   end

   assign bus.out_vals  = out_w;
   assign bus.cfg_out   = shadow[CFG_LEN-1];
   assign bus.cfg_ready = (bit_cnt == CNT_FULL);
   assign bus.cfg_err   = cfg_err_q;
   assign bus.active    = is_active;
endmodule
